// File: rtl/space_avail_multi_pkg.sv
// Shared defaults, credit update encoding and parameter helpers for the
// multi-channel credit tracker.
package space_avail_multi_pkg;

    localparam int DEF_NUM_CH      = 4;
    localparam int DEF_BUFFER_SIZE = 4;
    localparam int DEF_BUFFER_BITS = 3;

    typedef enum logic [1:0] {
        CREDIT_HOLD = 2'd0,
        CREDIT_UP   = 2'd1,
        CREDIT_DOWN = 2'd2
    } credit_op_t;

    // Smallest counter width able to hold every value 0..size.
    function automatic int min_buffer_bits(input int size);
        int bits;
        bits = 1;
        while ((1 << bits) <= size) begin
            bits++;
        end
        return bits;
    endfunction

endpackage

// File: rtl/space_avail_ch.sv
// Single-channel credit counter with lookahead space flag, sticky
// under/overflow error and the channel's contribution to the idle reduction.
module space_avail_ch
    import space_avail_multi_pkg::*;
#(
    parameter int BUFFER_SIZE = DEF_BUFFER_SIZE,
    parameter int BUFFER_BITS = DEF_BUFFER_BITS
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   valid,
    input  logic                   yummy,
    input  logic                   err_clr,
    output logic                   spc_avail,
    output logic [BUFFER_BITS-1:0] count,
    output logic                   credit_err,
    output logic                   idle_term
);

    localparam logic [BUFFER_BITS-1:0] FULL       = BUFFER_BITS'(BUFFER_SIZE);
    localparam logic [BUFFER_BITS-1:0] ONE        = BUFFER_BITS'(1);
    localparam logic [BUFFER_BITS-1:0] ZERO       = '0;
    localparam logic                   RST_IS_ONE = (BUFFER_SIZE == 1);
    localparam logic                   RST_IS_TWO = (BUFFER_SIZE >= 2);

    logic                   valid_f;
    logic                   yummy_f;
    logic                   is_one_f;
    logic                   is_two_or_more_f;
    credit_op_t             op;
    logic [BUFFER_BITS-1:0] count_next;
    logic                   sat_err;
    logic                   err_next;
    logic                   is_one_next;
    logic                   is_two_or_more_next;

    always_comb begin
        op = CREDIT_HOLD;
        if (yummy_f && !valid_f) begin
            op = CREDIT_UP;
        end else if (valid_f && !yummy_f) begin
            op = CREDIT_DOWN;
        end
    end

    // Saturating update: a push past either limit is a protocol error and
    // leaves the count pinned at that limit.
    always_comb begin
        count_next = count;
        sat_err    = 1'b0;
        case (op)
            CREDIT_UP: begin
                if (count == FULL) begin
                    sat_err = 1'b1;
                end else begin
                    count_next = count + ONE;
                end
            end
            CREDIT_DOWN: begin
                if (count == ZERO) begin
                    sat_err = 1'b1;
                end else begin
                    count_next = count - ONE;
                end
            end
            default: begin
            end
        endcase
        is_one_next         = (count_next == ONE);
        is_two_or_more_next = (count_next != ZERO) && (count_next != ONE);
        err_next            = sat_err | (credit_err & ~err_clr);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_f          <= 1'b0;
            yummy_f          <= 1'b0;
            count            <= FULL;
            is_one_f         <= RST_IS_ONE;
            is_two_or_more_f <= RST_IS_TWO;
            credit_err       <= 1'b0;
        end else begin
            valid_f          <= valid;
            yummy_f          <= yummy;
            count            <= count_next;
            is_one_f         <= is_one_next;
            is_two_or_more_f <= is_two_or_more_next;
            credit_err       <= err_next;
        end
    end

    // A returning credit frees a slot this cycle; a single remaining credit
    // is usable only if the flit in flight has not already claimed it.
    assign spc_avail = is_two_or_more_f | yummy_f | (is_one_f & ~valid_f);

    assign idle_term = (count_next == FULL) & ~valid & ~yummy;

endmodule

// File: rtl/space_avail_multi.sv
// NUM_CH independent credit trackers for a NoC output port, with packed
// count visibility and a registered all-credits-home indicator.
module space_avail_multi
    import space_avail_multi_pkg::*;
#(
    parameter int NUM_CH      = DEF_NUM_CH,
    parameter int BUFFER_SIZE = DEF_BUFFER_SIZE,
    parameter int BUFFER_BITS = DEF_BUFFER_BITS
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_CH-1:0]             valid,
    input  logic [NUM_CH-1:0]             yummy,
    input  logic                          err_clr,
    output logic [NUM_CH-1:0]             spc_avail,
    output logic [NUM_CH*BUFFER_BITS-1:0] count_out,
    output logic [NUM_CH-1:0]             credit_err,
    output logic                          all_idle
);

    if (BUFFER_SIZE < 1) begin : g_bad_size
        $error("space_avail_multi: BUFFER_SIZE must be at least 1");
    end

    if (BUFFER_BITS < min_buffer_bits(BUFFER_SIZE)) begin : g_bad_bits
        $error("space_avail_multi: BUFFER_BITS too narrow to hold BUFFER_SIZE");
    end

    logic [NUM_CH-1:0] idle_term;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        space_avail_ch #(
            .BUFFER_SIZE (BUFFER_SIZE),
            .BUFFER_BITS (BUFFER_BITS)
        ) u_ch (
            .clk        (clk),
            .reset      (reset),
            .valid      (valid[i]),
            .yummy      (yummy[i]),
            .err_clr    (err_clr),
            .spc_avail  (spc_avail[i]),
            .count      (count_out[i*BUFFER_BITS +: BUFFER_BITS]),
            .credit_err (credit_err[i]),
            .idle_term  (idle_term[i])
        );
    end

    // Registered so the drain indicator lines up with the registered counts.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            all_idle <= 1'b1;
        end else begin
            all_idle <= &idle_term;
        end
    end

endmodule

// File: tb/tb_space_avail_multi.sv
// Self-checking bench: directed vector table, hand-written corner sequences
// and randomized traffic against an arithmetic credit model.
module tb_space_avail_multi;

    localparam int NCH  = 4;
    localparam int BS   = 4;
    localparam int BB   = 3;
    localparam int NCH1 = 2;
    localparam int BS1  = 1;
    localparam int BB1  = 1;

    logic                 clk = 1'b0;
    logic                 reset;
    logic [NCH-1:0]       valid;
    logic [NCH-1:0]       yummy;
    logic                 err_clr;
    logic [NCH-1:0]       spc_avail;
    logic [NCH*BB-1:0]    count_out;
    logic [NCH-1:0]       credit_err;
    logic                 all_idle;

    logic [NCH1-1:0]      valid1;
    logic [NCH1-1:0]      yummy1;
    logic [NCH1-1:0]      spc_avail1;
    logic [NCH1*BB1-1:0]  count_out1;
    logic [NCH1-1:0]      credit_err1;
    logic                 all_idle1;

    int n_checks = 0;
    int n_fail   = 0;

    int m_cred[NCH];
    bit m_pv[NCH];
    bit m_py[NCH];
    bit m_err[NCH];
    bit m_idle;

    typedef struct {
        logic [NCH-1:0]    v;
        logic [NCH-1:0]    y;
        logic              c;
        logic [NCH-1:0]    avail;
        logic [NCH*BB-1:0] cnt;
        logic [NCH-1:0]    err;
        logic              idle;
    } vec_t;

    vec_t tbl[23];

    always #5 clk = ~clk;

    space_avail_multi #(.NUM_CH(NCH), .BUFFER_SIZE(BS), .BUFFER_BITS(BB)) dut (
        .clk        (clk),
        .reset      (reset),
        .valid      (valid),
        .yummy      (yummy),
        .err_clr    (err_clr),
        .spc_avail  (spc_avail),
        .count_out  (count_out),
        .credit_err (credit_err),
        .all_idle   (all_idle)
    );

    space_avail_multi #(.NUM_CH(NCH1), .BUFFER_SIZE(BS1), .BUFFER_BITS(BB1)) dut1 (
        .clk        (clk),
        .reset      (reset),
        .valid      (valid1),
        .yummy      (yummy1),
        .err_clr    (err_clr),
        .spc_avail  (spc_avail1),
        .count_out  (count_out1),
        .credit_err (credit_err1),
        .all_idle   (all_idle1)
    );

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic modelReset();
        for (int ch = 0; ch < NCH; ch++) begin
            m_cred[ch] = BS;
            m_pv[ch]   = 1'b0;
            m_py[ch]   = 1'b0;
            m_err[ch]  = 1'b0;
        end
        m_idle = 1'b1;
    endtask

    // Credits change by (returned - sent) one edge after the link activity is
    // registered; any excursion outside 0..BS is clipped and flagged.
    task automatic modelStep(input logic [NCH-1:0] v, input logic [NCH-1:0] y, input logic c);
        bit idle;
        idle = 1'b1;
        for (int ch = 0; ch < NCH; ch++) begin
            int n;
            bit e;
            n = m_cred[ch] + int'(m_py[ch]) - int'(m_pv[ch]);
            e = 1'b0;
            if (n < 0) begin
                n = 0;
                e = 1'b1;
            end
            if (n > BS) begin
                n = BS;
                e = 1'b1;
            end
            m_err[ch]  = e | (m_err[ch] & !c);
            m_cred[ch] = n;
            if (n != BS || v[ch] || y[ch]) idle = 1'b0;
            m_pv[ch] = v[ch];
            m_py[ch] = y[ch];
        end
        m_idle = idle;
    endtask

    function automatic logic [NCH-1:0] modelAvail();
        logic [NCH-1:0] r;
        for (int ch = 0; ch < NCH; ch++) begin
            r[ch] = ((m_cred[ch] + int'(m_py[ch]) - int'(m_pv[ch])) > 0) || m_py[ch];
        end
        return r;
    endfunction

    function automatic logic [NCH*BB-1:0] modelCount();
        logic [NCH*BB-1:0] r;
        for (int ch = 0; ch < NCH; ch++) begin
            r[ch*BB +: BB] = BB'(m_cred[ch]);
        end
        return r;
    endfunction

    function automatic logic [NCH-1:0] modelErr();
        logic [NCH-1:0] r;
        for (int ch = 0; ch < NCH; ch++) begin
            r[ch] = m_err[ch];
        end
        return r;
    endfunction

    task automatic applyStimulus(input logic [NCH-1:0] v, input logic [NCH-1:0] y, input logic c,
                                 input logic [NCH1-1:0] v1 = '0, input logic [NCH1-1:0] y1 = '0);
        valid   = v;
        yummy   = y;
        err_clr = c;
        valid1  = v1;
        yummy1  = y1;
        @(posedge clk);
        modelStep(v, y, c);
        @(negedge clk);
    endtask

    task automatic checkModel(input string tag);
        checkOutput({tag, " spc_avail"},  32'(spc_avail),  32'(modelAvail()));
        checkOutput({tag, " count_out"},  32'(count_out),  32'(modelCount()));
        checkOutput({tag, " credit_err"}, 32'(credit_err), 32'(modelErr()));
        checkOutput({tag, " all_idle"},   32'(all_idle),   32'(m_idle));
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        tbl[0]  = '{4'b0001, 4'b0000, 1'b0, 4'b1111, 12'h924, 4'b0000, 1'b0};
        tbl[1]  = '{4'b0001, 4'b0000, 1'b0, 4'b1111, 12'h923, 4'b0000, 1'b0};
        tbl[2]  = '{4'b0001, 4'b0000, 1'b0, 4'b1111, 12'h922, 4'b0000, 1'b0};
        tbl[3]  = '{4'b0001, 4'b0000, 1'b0, 4'b1110, 12'h921, 4'b0000, 1'b0};
        tbl[4]  = '{4'b0000, 4'b0000, 1'b0, 4'b1110, 12'h920, 4'b0000, 1'b0};
        tbl[5]  = '{4'b0000, 4'b0000, 1'b0, 4'b1110, 12'h920, 4'b0000, 1'b0};
        tbl[6]  = '{4'b0000, 4'b0001, 1'b0, 4'b1111, 12'h920, 4'b0000, 1'b0};
        tbl[7]  = '{4'b0000, 4'b0001, 1'b0, 4'b1111, 12'h921, 4'b0000, 1'b0};
        tbl[8]  = '{4'b0000, 4'b0000, 1'b0, 4'b1111, 12'h922, 4'b0000, 1'b0};
        tbl[9]  = '{4'b0000, 4'b0000, 1'b0, 4'b1111, 12'h922, 4'b0000, 1'b0};
        tbl[10] = '{4'b0010, 4'b0000, 1'b0, 4'b1111, 12'h922, 4'b0000, 1'b0};
        tbl[11] = '{4'b0010, 4'b0000, 1'b0, 4'b1111, 12'h91A, 4'b0000, 1'b0};
        tbl[12] = '{4'b0010, 4'b0010, 1'b0, 4'b1111, 12'h912, 4'b0000, 1'b0};
        tbl[13] = '{4'b0010, 4'b0010, 1'b0, 4'b1111, 12'h912, 4'b0000, 1'b0};
        tbl[14] = '{4'b0010, 4'b0010, 1'b0, 4'b1111, 12'h912, 4'b0000, 1'b0};
        tbl[15] = '{4'b0010, 4'b0010, 1'b0, 4'b1111, 12'h912, 4'b0000, 1'b0};
        tbl[16] = '{4'b0000, 4'b0000, 1'b0, 4'b1111, 12'h912, 4'b0000, 1'b0};
        tbl[17] = '{4'b0000, 4'b0100, 1'b0, 4'b1111, 12'h912, 4'b0000, 1'b0};
        tbl[18] = '{4'b0000, 4'b0000, 1'b0, 4'b1111, 12'h912, 4'b0100, 1'b0};
        tbl[19] = '{4'b0000, 4'b0000, 1'b0, 4'b1111, 12'h912, 4'b0100, 1'b0};
        tbl[20] = '{4'b0000, 4'b0000, 1'b1, 4'b1111, 12'h912, 4'b0000, 1'b0};
        tbl[21] = '{4'b0000, 4'b0100, 1'b0, 4'b1111, 12'h912, 4'b0000, 1'b0};
        tbl[22] = '{4'b0000, 4'b0000, 1'b1, 4'b1111, 12'h912, 4'b0100, 1'b0};

        reset   = 1'b1;
        valid   = '0;
        yummy   = '0;
        err_clr = 1'b0;
        valid1  = '0;
        yummy1  = '0;
        #1 reset = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);

        $display("[TB] reset defaults");
        checkOutput("rst spc_avail",   32'(spc_avail),   32'h0000_000F);
        checkOutput("rst count_out",   32'(count_out),   32'h0000_0924);
        checkOutput("rst credit_err",  32'(credit_err),  32'h0);
        checkOutput("rst all_idle",    32'(all_idle),    32'h1);
        checkOutput("rst1 spc_avail",  32'(spc_avail1),  32'h3);
        checkOutput("rst1 count_out",  32'(count_out1),  32'h3);
        checkOutput("rst1 credit_err", 32'(credit_err1), 32'h0);
        checkOutput("rst1 all_idle",   32'(all_idle1),   32'h1);
        reset = 1'b1;
        modelReset();

        $display("[TB] directed vector table");
        for (int k = 0; k < 23; k++) begin
            applyStimulus(tbl[k].v, tbl[k].y, tbl[k].c);
            checkOutput($sformatf("tbl%0d spc_avail", k),  32'(spc_avail),  32'(tbl[k].avail));
            checkOutput($sformatf("tbl%0d count_out", k),  32'(count_out),  32'(tbl[k].cnt));
            checkOutput($sformatf("tbl%0d credit_err", k), 32'(credit_err), 32'(tbl[k].err));
            checkOutput($sformatf("tbl%0d all_idle", k),   32'(all_idle),   32'(tbl[k].idle));
        end

        $display("[TB] underflow on channel 3");
        repeat (5) applyStimulus(4'b1000, 4'b0000, 1'b0);
        applyStimulus(4'b0000, 4'b0000, 1'b0);
        checkOutput("uflow count3", 32'(count_out[11:9]), 32'h0);
        checkOutput("uflow err3",   32'(credit_err[3]),   32'h1);
        checkOutput("uflow avail3", 32'(spc_avail[3]),    32'h0);
        applyStimulus(4'b0000, 4'b0000, 1'b0);
        checkOutput("uflow sticky", 32'(credit_err),      32'hC);
        applyStimulus(4'b0000, 4'b0000, 1'b1);
        checkOutput("errclr all",   32'(credit_err),      32'h0);
        checkOutput("errclr count", 32'(count_out),       32'h112);

        $display("[TB] refill to all idle");
        repeat (2) applyStimulus(4'b0000, 4'b1011, 1'b0);
        repeat (2) applyStimulus(4'b0000, 4'b1000, 1'b0);
        applyStimulus(4'b0000, 4'b0000, 1'b0);
        applyStimulus(4'b0000, 4'b0000, 1'b0);
        checkOutput("refill count_out", 32'(count_out),  32'h924);
        checkOutput("refill all_idle",  32'(all_idle),   32'h1);
        checkOutput("refill err",       32'(credit_err), 32'h0);
        checkModel("refill model");

        $display("[TB] randomized traffic");
        for (int k = 0; k < 800; k++) begin
            logic [NCH-1:0] v;
            logic [NCH-1:0] y;
            logic           c;
            v = NCH'($urandom);
            if ($urandom_range(0, 1) == 1) v = v & spc_avail;
            y = NCH'($urandom & $urandom);
            c = ($urandom_range(0, 15) == 0);
            applyStimulus(v, y, c);
            checkModel($sformatf("rand%0d", k));
        end

        applyStimulus(4'b0000, 4'b0000, 1'b0);
        checkModel("post-rand");

        $display("[TB] single-credit build");
        applyStimulus('0, '0, 1'b0, 2'b01, 2'b00);
        checkOutput("bs1 valid avail", 32'(spc_avail1), 32'h2);
        applyStimulus('0, '0, 1'b0, 2'b00, 2'b00);
        checkOutput("bs1 drained avail", 32'(spc_avail1), 32'h2);
        checkOutput("bs1 drained count", 32'(count_out1), 32'h2);
        applyStimulus('0, '0, 1'b0, 2'b00, 2'b01);
        checkOutput("bs1 yummy avail", 32'(spc_avail1), 32'h3);
        checkOutput("bs1 yummy count", 32'(count_out1), 32'h2);
        applyStimulus('0, '0, 1'b0, 2'b00, 2'b00);
        checkOutput("bs1 refill count", 32'(count_out1),  32'h3);
        checkOutput("bs1 refill err",   32'(credit_err1), 32'h0);
        applyStimulus('0, '0, 1'b0, 2'b11, 2'b00);
        checkOutput("bs1 both sent avail", 32'(spc_avail1), 32'h0);
        applyStimulus('0, '0, 1'b0, 2'b00, 2'b00);
        checkOutput("bs1 both empty count", 32'(count_out1), 32'h0);

        #2 reset = 1'b0;
        #1;
        checkOutput("midrst1 count_out", 32'(count_out1), 32'h3);
        checkOutput("midrst1 spc_avail", 32'(spc_avail1), 32'h3);
        checkOutput("midrst1 all_idle",  32'(all_idle1),  32'h1);
        checkOutput("midrst count_out",  32'(count_out),  32'h924);
        checkOutput("midrst credit_err", 32'(credit_err), 32'h0);
        @(negedge clk);
        reset = 1'b1;
        modelReset();
        applyStimulus(4'b0000, 4'b0000, 1'b0);
        checkModel("after reset");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
